// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32I writeback path.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_sel_e;

    // Load funct3 encodings; 011, 110 and 111 are reserved and read as a full word.
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Load-data extraction: picks a byte/half out of the aligned memory word and extends it.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] value
);

    if (XLEN != 32) begin : g_xlen_check
        $error("load_extend: byte/half extraction is only defined for XLEN = 32");
    end

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed byte/half; half selection ignores offset[0] since misalignment traps upstream.
    always_comb begin
        byte_v = word[8*offset +: 8];
        half_v = offset[1] ? word[31:16] : word[15:0];
        value  = word;
        case (load_type)
            LT_LB:   value = {{(XLEN-8){byte_v[7]}}, byte_v};
            LT_LBU:  value = {{(XLEN-8){1'b0}}, byte_v};
            LT_LH:   value = {{(XLEN-16){half_v[15]}}, half_v};
            LT_LHU:  value = {{(XLEN-16){1'b0}}, half_v};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, result selection, x0-safe write enable and retire counter.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall_W,
    input  logic                  i_flush_W,
    input  logic                  i_valid_M,
    input  logic [XLEN-1:0]       i_ALU_output_M,
    input  logic [XLEN-1:0]       i_rd_data_M,
    input  logic [XLEN-1:0]       i_pc_plus4_M,
    input  logic [XLEN-1:0]       i_imm_M,
    input  logic [REG_ADDR_W-1:0] i_register_file_wr_addr_M,
    input  logic                  i_register_file_wr_en_M,
    input  logic [1:0]            i_sel_result_M,
    input  logic [2:0]            i_load_type_M,
    output logic [XLEN-1:0]       o_result_W,
    output logic                  o_register_file_wr_en_W,
    output logic [REG_ADDR_W-1:0] o_register_file_wr_addr_W,
    output logic                  o_valid_W,
    output logic [CNT_W-1:0]      o_retired_count_W
);

    logic                  valid_q;
    logic                  wr_en_q;
    logic [REG_ADDR_W-1:0] wr_addr_q;
    result_sel_e           sel_q;
    logic [2:0]            load_type_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       rd_data_q;
    logic [XLEN-1:0]       pc4_q;
    logic [XLEN-1:0]       imm_q;
    logic [CNT_W-1:0]      count_q;
    logic [XLEN-1:0]       load_value;

    // WB register: reset beats flush beats stall beats capture; flush zeroes the whole slot.
    always_ff @(posedge clk) begin
        if (rst || i_flush_W) begin
            valid_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            sel_q       <= RES_ALU;
            load_type_q <= '0;
            alu_q       <= '0;
            rd_data_q   <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
        end else if (!i_stall_W) begin
            valid_q     <= i_valid_M;
            wr_en_q     <= i_register_file_wr_en_M;
            wr_addr_q   <= i_register_file_wr_addr_M;
            sel_q       <= result_sel_e'(i_sel_result_M);
            load_type_q <= i_load_type_M;
            alu_q       <= i_ALU_output_M;
            rd_data_q   <= i_rd_data_M;
            pc4_q       <= i_pc_plus4_M;
            imm_q       <= i_imm_M;
        end
    end

    // Count an instruction once, on the edge it enters WB; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (!i_flush_W && !i_stall_W && i_valid_M) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .word      (rd_data_q),
        .offset    (alu_q[1:0]),
        .load_type (load_type_q),
        .value     (load_value)
    );

    // Result mux driven purely from registered state.
    always_comb begin
        o_result_W = alu_q;
        case (sel_q)
            RES_ALU:  o_result_W = alu_q;
            RES_LOAD: o_result_W = load_value;
            RES_PC4:  o_result_W = pc4_q;
            RES_IMM:  o_result_W = imm_q;
            default:  o_result_W = alu_q;
        endcase
    end

    assign o_register_file_wr_en_W   = valid_q & wr_en_q & (wr_addr_q != '0);
    assign o_register_file_wr_addr_W = wr_addr_q;
    assign o_valid_W                 = valid_q;
    assign o_retired_count_W         = count_q;

endmodule
